// File: rtl/fnn_cfg_pkg.sv
// Shared definitions for the FNN configuration path: loader state encoding,
// header field positions and the default network dimensions used by the weight memories.
package fnn_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      DONE
   } cfg_state_t;

   localparam int cfg_width      = 32;
   localparam int hdr_layer_msb  = 31;
   localparam int hdr_layer_lsb  = 28;
   localparam int hdr_neuron_msb = 27;
   localparam int hdr_neuron_lsb = 20;
   localparam int hdr_count_msb  = 19;
   localparam int hdr_count_lsb  = 0;

   localparam int def_num_layers  = 4;
   localparam int def_max_neurons = 32;
   localparam int def_num_weight  = 30;
   localparam int def_data_width  = 16;

endpackage

// File: rtl/weight_loader_if.sv
// Bundles the host configuration stream and the weight-memory write port.
// The loader is the slave; the host/memory side is the master.
interface weight_loader_if
   import fnn_cfg_pkg::*;
#(
   parameter int numLayers  = def_num_layers,
   parameter int maxNeurons = def_max_neurons,
   parameter int numWeight  = def_num_weight,
   parameter int dataWidth  = def_data_width
);

   localparam int addressWidth = $clog2(numWeight);
   localparam int layerWidth   = $clog2(numLayers);
   localparam int neuronWidth  = $clog2(maxNeurons);

   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [cfg_width-1:0]    cfg_data;
   logic                    cfg_last;
   logic                    wen;
   logic [layerWidth-1:0]   wlayer;
   logic [neuronWidth-1:0]  wneuron;
   logic [addressWidth-1:0] wadd;
   logic [dataWidth-1:0]    win;
   logic                    load_done;
   logic                    load_err;

   modport master (
      output cfg_valid, cfg_data, cfg_last,
      input  cfg_ready, wen, wlayer, wneuron, wadd, win, load_done, load_err
   );

   modport slave (
      input  cfg_valid, cfg_data, cfg_last,
      output cfg_ready, wen, wlayer, wneuron, wadd, win, load_done, load_err
   );

endinterface

// File: rtl/weight_wr_decode.sv
// Expands the loader's layer/neuron select into one write enable per neuron memory.
// Lives at the system top, next to the memories it drives.
module weight_wr_decode
   import fnn_cfg_pkg::*;
#(
   parameter int numLayers   = def_num_layers,
   parameter int maxNeurons  = def_max_neurons,
   parameter int layerWidth  = $clog2(numLayers),
   parameter int neuronWidth = $clog2(maxNeurons)
) (
   input  logic                             wen,
   input  logic [layerWidth-1:0]            wlayer,
   input  logic [neuronWidth-1:0]           wneuron,
   output logic [numLayers*maxNeurons-1:0]  mem_wen
);

   localparam int selWidth = $clog2(numLayers * maxNeurons);

   logic [selWidth-1:0] sel;

   // Memories are numbered layer-major: layer * maxNeurons + neuron.
   always_comb begin
      sel     = selWidth'(32'(wlayer) * maxNeurons + 32'(wneuron));
      mem_wen = '0;
      if (wen) begin
         mem_wen[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/weight_loader.sv
// Turns a header + weight-beat configuration stream into single-cycle writes
// into the per-neuron weight memories, flagging malformed packets.
module weight_loader
   import fnn_cfg_pkg::*;
#(
   parameter int numLayers    = def_num_layers,
   parameter int maxNeurons   = def_max_neurons,
   parameter int numWeight    = def_num_weight,
   parameter int dataWidth    = def_data_width,
   parameter int addressWidth = $clog2(numWeight),
   parameter int layerWidth   = $clog2(numLayers),
   parameter int neuronWidth  = $clog2(maxNeurons)
) (
   input logic            clk,
   input logic            rst_n,
   weight_loader_if.slave bus
);

   // Wide enough to hold numWeight itself, not just the last address.
   localparam int countWidth = $clog2(numWeight + 1);

   cfg_state_t              state, state_next;
   logic                    ready_q, ready_next;
   logic                    wen_q, wen_next;
   logic [layerWidth-1:0]   layer_q, layer_next;
   logic [neuronWidth-1:0]  neuron_q, neuron_next;
   logic [addressWidth-1:0] wadd_q, wadd_next;
   logic [dataWidth-1:0]    win_q, win_next;
   logic                    done_q, done_next;
   logic                    err_q, err_next;
   logic [countWidth-1:0]   count_q, count_next;
   logic [countWidth-1:0]   index_q, index_next;

   logic                                   accept;
   logic [hdr_layer_msb-hdr_layer_lsb:0]   hdr_layer;
   logic [hdr_neuron_msb-hdr_neuron_lsb:0] hdr_neuron;
   logic [hdr_count_msb-hdr_count_lsb:0]   hdr_count;
   logic                                   hdr_ok;
   logic                                   final_beat;

   assign accept     = bus.cfg_valid & ready_q;
   assign hdr_layer  = bus.cfg_data[hdr_layer_msb:hdr_layer_lsb];
   assign hdr_neuron = bus.cfg_data[hdr_neuron_msb:hdr_neuron_lsb];
   assign hdr_count  = bus.cfg_data[hdr_count_msb:hdr_count_lsb];
   assign hdr_ok     = (hdr_count != '0) &&
                       (32'(hdr_count) <= numWeight) &&
                       (32'(hdr_layer) < numLayers) &&
                       (32'(hdr_neuron) < maxNeurons);
   assign final_beat = (index_q + 1'b1) == count_q;

   always_comb begin
      state_next  = state;
      wen_next    = 1'b0;
      done_next   = 1'b0;
      err_next    = err_q;
      layer_next  = layer_q;
      neuron_next = neuron_q;
      wadd_next   = wadd_q;
      win_next    = win_q;
      count_next  = count_q;
      index_next  = index_q;

      case (state)
         IDLE: begin
            if (accept) begin
               err_next = 1'b0;
               if (hdr_ok) begin
                  layer_next  = hdr_layer[layerWidth-1:0];
                  neuron_next = hdr_neuron[neuronWidth-1:0];
                  count_next  = hdr_count[countWidth-1:0];
                  index_next  = '0;
                  state_next  = LOAD;
               end else begin
                  err_next   = 1'b1;
                  state_next = bus.cfg_last ? IDLE : DRAIN;
               end
            end
         end
         LOAD: begin
            // Every accepted beat is written, even when it ends the packet badly.
            if (accept) begin
               wen_next   = 1'b1;
               wadd_next  = index_q[addressWidth-1:0];
               win_next   = bus.cfg_data[dataWidth-1:0];
               index_next = index_q + 1'b1;
               if (final_beat) begin
                  if (bus.cfg_last) begin
                     done_next  = 1'b1;
                     state_next = DONE;
                  end else begin
                     err_next   = 1'b1;
                     state_next = DRAIN;
                  end
               end else if (bus.cfg_last) begin
                  err_next   = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         DRAIN: begin
            if (accept && bus.cfg_last) begin
               state_next = IDLE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      ready_next = (state_next != DONE);
   end

   // All outputs are registered so the memories see clean, glitch-free strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready_q  <= 1'b0;
         wen_q    <= 1'b0;
         layer_q  <= '0;
         neuron_q <= '0;
         wadd_q   <= '0;
         win_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         count_q  <= '0;
         index_q  <= '0;
      end else begin
         state    <= state_next;
         ready_q  <= ready_next;
         wen_q    <= wen_next;
         layer_q  <= layer_next;
         neuron_q <= neuron_next;
         wadd_q   <= wadd_next;
         win_q    <= win_next;
         done_q   <= done_next;
         err_q    <= err_next;
         count_q  <= count_next;
         index_q  <= index_next;
      end
   end

   assign bus.cfg_ready = ready_q;
   assign bus.wen       = wen_q;
   assign bus.wlayer    = layer_q;
   assign bus.wneuron   = neuron_q;
   assign bus.wadd      = wadd_q;
   assign bus.win       = win_q;
   assign bus.load_done = done_q;
   assign bus.load_err  = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: expected memory writes are queued as beats
// are accepted and matched against the write port one cycle later.
module tb_weight_loader;
   import fnn_cfg_pkg::*;

   typedef struct {
      logic [4:0]  wadd;
      logic [15:0] win;
      logic [1:0]  layer;
      logic [4:0]  neuron;
      logic        done;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic [127:0] mem_wen;

   exp_t        sb[$];
   int          compare_count  = 0;
   int          mismatch_count = 0;
   logic [1:0]  exp_layer  = '0;
   logic [4:0]  exp_neuron = '0;

   weight_loader_if bus ();

   weight_loader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   weight_wr_decode dec (
      .wen     (bus.wen),
      .wlayer  (bus.wlayer),
      .wneuron (bus.wneuron),
      .mem_wen (mem_wen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      compare_count++;
      if (actual !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] hdr(input int layer, input int neuron, input int count);
      return {4'(layer), 8'(neuron), 20'(count)};
   endfunction

   // Drives one beat, waits (bounded) for acceptance and queues the write it should cause.
   task automatic applyStimulus(input logic [31:0] data, input logic last, input bit write,
                                input int addr, input logic [15:0] exp_win, input bit done);
      int waited;
      waited = 0;
      @(negedge clk);
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = data;
      bus.cfg_last  = last;
      while (!bus.cfg_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.cfg_ready) begin
         checkOutput("ready_timeout", 0, 1);
         bus.cfg_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         bus.cfg_valid = 1'b0;
         if (write) begin
            sb.push_back('{5'(addr), exp_win, exp_layer, exp_neuron, done});
         end
      end
   endtask

   // Write-port monitor: a queued write must appear exactly one cycle after acceptance.
   initial begin
      exp_t         e;
      logic [127:0] onehot;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (sb.size() > 0) begin
               e = sb.pop_front();
               onehot = '0;
               onehot[32'(e.layer) * 32 + 32'(e.neuron)] = 1'b1;
               checkOutput("wen",       bus.wen,       1);
               checkOutput("wadd",      bus.wadd,      e.wadd);
               checkOutput("win",       bus.win,       e.win);
               checkOutput("wlayer",    bus.wlayer,    e.layer);
               checkOutput("wneuron",   bus.wneuron,   e.neuron);
               checkOutput("load_done", bus.load_done, e.done);
               checkOutput("mem_wen",   mem_wen,       onehot);
            end else begin
               checkOutput("stray_wen",  bus.wen,       0);
               checkOutput("stray_done", bus.load_done, 0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = '0;
      bus.cfg_last  = 1'b0;
      #23;
      checkOutput("rst_ready",   bus.cfg_ready, 0);
      checkOutput("rst_wen",     bus.wen,       0);
      checkOutput("rst_wlayer",  bus.wlayer,    0);
      checkOutput("rst_wneuron", bus.wneuron,   0);
      checkOutput("rst_wadd",    bus.wadd,      0);
      checkOutput("rst_win",     bus.win,       0);
      checkOutput("rst_done",    bus.load_done, 0);
      checkOutput("rst_err",     bus.load_err,  0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ready_after_reset", bus.cfg_ready, 1);

      $display("[TB] good packet: layer 2 neuron 22, 30 weights");
      exp_layer  = 2'd2;
      exp_neuron = 5'd22;
      applyStimulus(hdr(2, 22, 30), 1'b0, 0, 0, '0, 0);
      for (int i = 0; i < 30; i++) begin
         applyStimulus({16'hDEAD, 16'(16'h0100 + i)}, i == 29, 1, i, 16'(16'h0100 + i), i == 29);
      end
      checkOutput("done_ready_low", bus.cfg_ready, 0);
      checkOutput("good_err",       bus.load_err,  0);
      @(posedge clk);
      #1;
      checkOutput("ready_after_done", bus.cfg_ready, 1);

      $display("[TB] bad header: count 31, three beats drained");
      applyStimulus(hdr(1, 3, 31), 1'b0, 0, 0, '0, 0);
      checkOutput("count31_err", bus.load_err, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(32'h0000_5A00 + 32'(i), i == 2, 0, 0, '0, 0);
      end
      checkOutput("err_sticky", bus.load_err, 1);

      $display("[TB] early last: count 5, last on third weight");
      exp_layer  = 2'd0;
      exp_neuron = 5'd31;
      applyStimulus(hdr(0, 31, 5), 1'b0, 0, 0, '0, 0);
      checkOutput("err_cleared", bus.load_err, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(32'h0000_2000 + 32'(i), i == 2, 1, i, 16'(16'h2000 + i), 0);
      end
      checkOutput("early_last_err",   bus.load_err,  1);
      checkOutput("early_last_ready", bus.cfg_ready, 1);

      $display("[TB] missing last: count 2, extra beat drained");
      exp_layer  = 2'd3;
      exp_neuron = 5'd1;
      applyStimulus(hdr(3, 1, 2), 1'b0, 0, 0, '0, 0);
      applyStimulus(32'h0000_3000, 1'b0, 1, 0, 16'h3000, 0);
      applyStimulus(32'h0000_3001, 1'b0, 1, 1, 16'h3001, 0);
      checkOutput("no_last_err", bus.load_err, 1);
      applyStimulus(32'h0000_3002, 1'b1, 0, 0, '0, 0);

      $display("[TB] gap: count 4, valid low two cycles after beat 2");
      exp_layer  = 2'd1;
      exp_neuron = 5'd5;
      applyStimulus(hdr(1, 5, 4), 1'b0, 0, 0, '0, 0);
      checkOutput("gap_hdr_err", bus.load_err, 0);
      applyStimulus(32'h0000_4000, 1'b0, 1, 0, 16'h4000, 0);
      applyStimulus(32'h0000_4001, 1'b0, 1, 1, 16'h4001, 0);
      repeat (2) @(posedge clk);
      applyStimulus(32'h0000_4002, 1'b0, 1, 2, 16'h4002, 0);
      applyStimulus(32'h0000_4003, 1'b1, 1, 3, 16'h4003, 1);
      checkOutput("gap_err", bus.load_err, 0);

      $display("[TB] range: layer 4 rejected");
      applyStimulus(hdr(4, 0, 3), 1'b0, 0, 0, '0, 0);
      checkOutput("layer4_err", bus.load_err, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(32'h0000_6000 + 32'(i), i == 2, 0, 0, '0, 0);
      end
      checkOutput("layer4_ready", bus.cfg_ready, 1);

      $display("[TB] reset after ten writes of a 30-weight packet");
      exp_layer  = 2'd3;
      exp_neuron = 5'd31;
      applyStimulus(hdr(3, 31, 30), 1'b0, 0, 0, '0, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(32'h0000_7000 + 32'(i), 1'b0, 1, i, 16'(16'h7000 + i), 0);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_wen",   bus.wen,       0);
      checkOutput("async_rst_ready", bus.cfg_ready, 0);
      checkOutput("async_rst_wadd",  bus.wadd,      0);
      checkOutput("async_rst_win",   bus.win,       0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_layer  = 2'd1;
      exp_neuron = 5'd0;
      applyStimulus(hdr(1, 0, 2), 1'b0, 0, 0, '0, 0);
      applyStimulus(32'hFFFF_8000, 1'b0, 1, 0, 16'h8000, 0);
      applyStimulus(32'hFFFF_8001, 1'b1, 1, 1, 16'h8001, 1);
      checkOutput("post_rst_err", bus.load_err, 0);

      repeat (3) @(negedge clk);
      checkOutput("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
